// File: rtl/ram_upload_reader_if.sv
// ram_upload_reader_if: hps_io ioctl upload lines plus the RAM read port.
// Handshake: the HPS pulses ioctl_rd for one cycle to ask for the byte at
// ioctl_addr. There is no ready/ack. The reader guarantees a fresh ioctl_din
// three cycles after the strobe, or two cycles for a fill byte.
// On the RAM side, mem_rd acts as a one-cycle valid for mem_addr, and mem_q
// is valid exactly one cycle later. The RAM never stalls.
interface ram_upload_reader_if;
   logic        ioctl_upload_req;
   logic        ioctl_upload;
   logic        ioctl_rd;
   logic [24:0] ioctl_addr;
   logic [7:0]  ioctl_din;
   logic [15:0] mem_addr;
   logic        mem_rd;
   logic [7:0]  mem_q;

   // Reader side: drives the upload request, the returned byte and the RAM port.
   modport master (
      output ioctl_upload_req, ioctl_din, mem_addr, mem_rd,
      input  ioctl_upload, ioctl_rd, ioctl_addr, mem_q
   );

   // Environment side: hps_io and the RAM.
   modport slave (
      input  ioctl_upload_req, ioctl_din, mem_addr, mem_rd,
      output ioctl_upload, ioctl_rd, ioctl_addr, mem_q
   );
endinterface

// File: rtl/ram_upload_reader.sv
// ram_upload_reader: serves main-RAM bytes to the HPS over the ioctl upload
// protocol so cartridge RAM can be saved to a file. While busy it owns the RAM
// address and read strobe.
module ram_upload_reader #(
   parameter logic [15:0] BASE_ADDR = 16'h7000,
   parameter logic [16:0] SIZE      = 17'h09000,
   parameter logic [7:0]  FILL      = 8'hFF,
   parameter logic [19:0] TIMEOUT   = 20'hFFFFF
) (
   input  logic                  clk_sys,
   input  logic                  reset,
   input  logic                  save_trig,
   ram_upload_reader_if.master   bus,
   output logic                  busy,
   output logic                  done,
   output logic                  timeout_err,
   output logic [2:0]            state_dbg
);

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_REQ     = 3'd1,
      ST_WAIT    = 3'd2,
      ST_ACTIVE  = 3'd3,
      ST_READ    = 3'd4,
      ST_CAPTURE = 3'd5
   } state_t;

   // Widened so offsets of 64 KiB and above compare as out of range instead of aliasing.
   localparam logic [24:0] SIZE_EXT = {8'd0, SIZE};

   state_t      state;
   logic        trig_d;
   logic [19:0] wait_cnt;
   logic [24:0] off;
   logic        pend;
   logic [24:0] pend_addr;
   logic        end_seen;

   logic [24:0] req_addr;
   logic        req_in_range;
   logic [15:0] req_mem_addr;
   logic        off_in_range;
   logic        session_over;

   assign state_dbg = state;

   // Pick the request to serve: a fresh strobe overrides a pending one.
   always_comb begin
      req_addr     = bus.ioctl_rd ? bus.ioctl_addr : pend_addr;
      req_in_range = (req_addr < SIZE_EXT);
      req_mem_addr = BASE_ADDR + req_addr[15:0];
      off_in_range = (off < SIZE_EXT);
      session_over = !bus.ioctl_upload || end_seen;
   end

   // Main FSM. All outputs are registered. The RAM strobe is issued on the
   // ACTIVE->READ edge so that the address is valid during READ.
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         state                <= ST_IDLE;
         trig_d               <= 1'b0;
         wait_cnt             <= 20'd0;
         off                  <= 25'd0;
         pend                 <= 1'b0;
         pend_addr            <= 25'd0;
         end_seen             <= 1'b0;
         bus.ioctl_upload_req <= 1'b0;
         bus.ioctl_din        <= 8'h00;
         bus.mem_addr         <= 16'h0000;
         bus.mem_rd           <= 1'b0;
         busy                 <= 1'b0;
         done                 <= 1'b0;
         timeout_err          <= 1'b0;
      end else begin
         trig_d               <= save_trig;
         bus.ioctl_upload_req <= 1'b0;
         bus.mem_rd           <= 1'b0;
         done                 <= 1'b0;
         timeout_err          <= 1'b0;

         case (state)
            ST_IDLE: begin
               if (save_trig && !trig_d) begin
                  state                <= ST_REQ;
                  bus.ioctl_upload_req <= 1'b1;
                  busy                 <= 1'b1;
               end else if (bus.ioctl_upload) begin
                  state    <= ST_ACTIVE;
                  end_seen <= 1'b0;
                  busy     <= 1'b1;
               end
            end

            ST_REQ: begin
               wait_cnt <= 20'd0;
               end_seen <= 1'b0;
               state    <= ST_WAIT;
            end

            ST_WAIT: begin
               if (bus.ioctl_upload) begin
                  state <= ST_ACTIVE;
               end else if (wait_cnt >= TIMEOUT - 20'd1) begin
                  state       <= ST_IDLE;
                  busy        <= 1'b0;
                  timeout_err <= 1'b1;
               end else begin
                  wait_cnt <= wait_cnt + 20'd1;
               end
            end

            ST_ACTIVE: begin
               if (!bus.ioctl_upload) begin
                  state <= ST_IDLE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  pend  <= 1'b0;
               end else if (bus.ioctl_rd || pend) begin
                  off   <= req_addr;
                  pend  <= 1'b0;
                  state <= ST_READ;
                  if (req_in_range) begin
                     bus.mem_rd   <= 1'b1;
                     bus.mem_addr <= req_mem_addr;
                  end
               end
            end

            ST_READ, ST_CAPTURE: begin
               if (bus.ioctl_rd) begin
                  pend      <= 1'b1;
                  pend_addr <= bus.ioctl_addr;
               end
               if (!bus.ioctl_upload) begin
                  end_seen <= 1'b1;
               end
               if (state == ST_READ && off_in_range) begin
                  state <= ST_CAPTURE;
               end else begin
                  bus.ioctl_din <= (state == ST_READ) ? FILL : bus.mem_q;
                  if (session_over) begin
                     state    <= ST_IDLE;
                     busy     <= 1'b0;
                     done     <= 1'b1;
                     pend     <= 1'b0;
                     end_seen <= 1'b0;
                  end else begin
                     state <= ST_ACTIVE;
                  end
               end
            end

            default: begin
               state <= ST_IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ram_upload_reader.sv
// tb_ram_upload_reader: directed bench for ram_upload_reader with a
// 64 KiB registered-read RAM model and a byte scoreboard.
module tb_ram_upload_reader;

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_REQ     = 3'd1;
   localparam logic [2:0] S_WAIT    = 3'd2;
   localparam logic [2:0] S_ACTIVE  = 3'd3;
   localparam logic [2:0] S_READ    = 3'd4;
   localparam logic [2:0] S_CAPTURE = 3'd5;

   logic       clk;
   logic       reset;
   logic       save_trig;
   logic       busy;
   logic       done;
   logic       timeout_err;
   logic [2:0] state_dbg;

   ram_upload_reader_if bus();

   ram_upload_reader #(
      .BASE_ADDR(16'h7000),
      .SIZE     (17'h09000),
      .FILL     (8'hFF),
      .TIMEOUT  (20'd16)
   ) dut (
      .clk_sys    (clk),
      .reset      (reset),
      .save_trig  (save_trig),
      .bus        (bus),
      .busy       (busy),
      .done       (done),
      .timeout_err(timeout_err),
      .state_dbg  (state_dbg)
   );

   int tests  = 0;
   int failed = 0;
   logic [7:0] exp_q[$];
   logic [7:0] ram [0:65535];

   // Clock / reset-independent RAM model
   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (bus.mem_rd) bus.mem_q <= ram[bus.mem_addr];
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Monitor: a byte is delivered when the FSM leaves READ/CAPTURE without reset.
   logic [2:0] prev_state = S_IDLE;
   logic       prev_rst   = 1'b1;
   always @(negedge clk) begin
      if (!prev_rst && (prev_state == S_READ || prev_state == S_CAPTURE) &&
          !(state_dbg == S_READ || state_dbg == S_CAPTURE)) begin
         if (exp_q.size() == 0) begin
            check("unexpected_byte", {24'd0, bus.ioctl_din}, 32'hDEAD);
         end else begin
            check("scoreboard_byte", {24'd0, bus.ioctl_din}, {24'd0, exp_q.pop_front()});
         end
      end
      prev_state = state_dbg;
      prev_rst   = reset;
   end

   // Driver: one ioctl_rd strobe in an ACTIVE cycle, with latency checks.
   task automatic do_read(input logic [24:0] a, input logic [7:0] exp_byte,
                          input logic in_range, input logic [15:0] exp_maddr);
      bus.ioctl_rd   = 1'b1;
      bus.ioctl_addr = a;
      exp_q.push_back(exp_byte);
      step();
      bus.ioctl_rd = 1'b0;
      @(negedge clk);
      check("mem_rd_t1", {31'd0, bus.mem_rd}, {31'd0, in_range});
      check("mem_addr_t1", {16'd0, bus.mem_addr}, {16'd0, exp_maddr});
      step();
      @(negedge clk);
      if (!in_range) check("fill_t2", {24'd0, bus.ioctl_din}, {24'd0, exp_byte});
      step();
      @(negedge clk);
      if (in_range) check("din_t3", {24'd0, bus.ioctl_din}, {24'd0, exp_byte});
      step();
   endtask

   initial begin
      int n;
      for (int i = 0; i < 65536; i++) ram[i] = i[7:0] ^ i[15:8];
      ram[16'h7000] = 8'h5A;
      ram[16'h7001] = 8'h11;
      ram[16'h7002] = 8'h22;
      ram[16'h7003] = 8'h33;
      ram[16'hFFFF] = 8'hC3;
      bus.mem_q        = 8'h00;
      reset            = 1'b1;
      save_trig        = 1'b0;
      bus.ioctl_upload = 1'b0;
      bus.ioctl_rd     = 1'b0;
      bus.ioctl_addr   = 25'd0;

      // Reset state
      repeat (3) step();
      reset = 1'b0;
      @(negedge clk);
      check("rst_state", {29'd0, state_dbg}, {29'd0, S_IDLE});
      check("rst_din", {24'd0, bus.ioctl_din}, 32'h00);
      check("rst_mem_addr", {16'd0, bus.mem_addr}, 32'h0000);
      check("rst_flags", {27'd0, bus.mem_rd, bus.ioctl_upload_req, busy, done, timeout_err}, 32'd0);

      // Triggered upload
      step();
      save_trig = 1'b1;
      step();
      @(negedge clk);
      check("req_pulse", {31'd0, bus.ioctl_upload_req}, 32'd1);
      check("req_busy", {31'd0, busy}, 32'd1);
      check("req_state", {29'd0, state_dbg}, {29'd0, S_REQ});
      step();
      @(negedge clk);
      check("req_single", {31'd0, bus.ioctl_upload_req}, 32'd0);
      check("wait_state", {29'd0, state_dbg}, {29'd0, S_WAIT});
      bus.ioctl_upload = 1'b1;
      save_trig = 1'b0;
      step();
      @(negedge clk);
      check("active_state", {29'd0, state_dbg}, {29'd0, S_ACTIVE});
      step();
      do_read(25'h0, 8'h5A, 1'b1, 16'h7000);

      // save_trig edge outside IDLE is ignored
      save_trig = 1'b1;
      step();
      @(negedge clk);
      check("trig_ignored", {31'd0, bus.ioctl_upload_req}, 32'd0);
      check("trig_ign_state", {29'd0, state_dbg}, {29'd0, S_ACTIVE});
      save_trig = 1'b0;
      step();

      // Last byte and range checks
      do_read(25'h0008FFF, 8'hC3, 1'b1, 16'hFFFF);
      do_read(25'h0009000, 8'hFF, 1'b0, 16'hFFFF);
      do_read(25'h0010000, 8'hFF, 1'b0, 16'hFFFF);
      do_read(25'h1FFFFFF, 8'hFF, 1'b0, 16'hFFFF);
      do_read(25'h0000003, 8'h33, 1'b1, 16'h7003);

      // Back-to-back strobes: addr 2 is replaced by addr 3
      bus.ioctl_rd = 1'b1; bus.ioctl_addr = 25'd1; exp_q.push_back(8'h11);
      step();
      bus.ioctl_addr = 25'd2;
      step();
      bus.ioctl_addr = 25'd3; exp_q.push_back(8'h33);
      step();
      bus.ioctl_rd = 1'b0;
      @(negedge clk);
      check("b2b_first", {24'd0, bus.ioctl_din}, 32'h11);
      step();
      @(negedge clk);
      check("b2b_pend_addr", {16'd0, bus.mem_addr}, 32'h7003);
      check("b2b_pend_rd", {31'd0, bus.mem_rd}, 32'd1);
      step();
      step();
      @(negedge clk);
      check("b2b_second", {24'd0, bus.ioctl_din}, 32'h33);
      step();

      // Normal end of session from ACTIVE
      bus.ioctl_upload = 1'b0;
      step();
      @(negedge clk);
      check("end_done", {31'd0, done}, 32'd1);
      check("end_state", {29'd0, state_dbg}, {29'd0, S_IDLE});
      check("end_busy", {31'd0, busy}, 32'd0);

      // HPS-initiated session, dropped during READ
      step();
      bus.ioctl_upload = 1'b1;
      step();
      @(negedge clk);
      check("hps_active", {29'd0, state_dbg}, {29'd0, S_ACTIVE});
      check("hps_no_req", {31'd0, bus.ioctl_upload_req}, 32'd0);
      step();
      bus.ioctl_rd = 1'b1; bus.ioctl_addr = 25'd0; exp_q.push_back(8'h5A);
      step();
      bus.ioctl_rd = 1'b0;
      bus.ioctl_upload = 1'b0;
      step();
      step();
      @(negedge clk);
      check("midread_done", {31'd0, done}, 32'd1);
      check("midread_state", {29'd0, state_dbg}, {29'd0, S_IDLE});
      check("midread_din", {24'd0, bus.ioctl_din}, 32'h5A);
      step();
      @(negedge clk);
      check("midread_done_once", {31'd0, done}, 32'd0);

      // Timeout after 16 WAIT cycles
      step();
      save_trig = 1'b1;
      step();
      save_trig = 1'b0;
      n = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (state_dbg == S_WAIT) n++;
         else if (n > 0) break;
      end
      check("to_wait_cycles", n, 32'd16);
      check("to_err", {31'd0, timeout_err}, 32'd1);
      check("to_state", {29'd0, state_dbg}, {29'd0, S_IDLE});
      check("to_busy", {31'd0, busy}, 32'd0);
      @(negedge clk);
      check("to_err_once", {31'd0, timeout_err}, 32'd0);

      // Reset during CAPTURE
      step();
      bus.ioctl_upload = 1'b1;
      step();
      step();
      bus.ioctl_rd = 1'b1; bus.ioctl_addr = 25'd2;
      step();
      bus.ioctl_rd = 1'b0;
      step();
      reset = 1'b1;
      bus.ioctl_upload = 1'b0;
      @(negedge clk);
      check("rst_in_capture", {29'd0, state_dbg}, {29'd0, S_CAPTURE});
      step();
      @(negedge clk);
      check("rstmid_state", {29'd0, state_dbg}, {29'd0, S_IDLE});
      check("rstmid_din", {24'd0, bus.ioctl_din}, 32'h00);
      check("rstmid_mem_addr", {16'd0, bus.mem_addr}, 32'h0000);
      check("rstmid_flags", {27'd0, bus.mem_rd, bus.ioctl_upload_req, busy, done, timeout_err}, 32'd0);
      reset = 1'b0;
      repeat (3) step();

      check("queue_empty", exp_q.size(), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule

// File: doc/ram_upload_reader.md
# ram_upload_reader

Upload-side counterpart to the cartridge/RAM download path: serves bytes of main RAM to the HPS over the hps_io `ioctl` upload protocol, so that cartridge RAM can be saved to a file. It sits in `emu` between `hps_io` and the 64 KiB `spram`. While active it takes over the RAM address and read strobe, and it raises `busy` so the top level holds the console in reset and muxes its address onto the RAM.

## Interface
Parameters:
- `BASE_ADDR`, default 16'h7000: RAM address that maps to upload offset 0.
- `SIZE`, default 17'h09000: number of bytes in the image (0x7000–0xFFFF).
- `FILL`, default 8'hFF: byte returned for offsets at or beyond `SIZE`.
- `TIMEOUT`, default 20'hFFFFF: cycles to wait for `ioctl_upload` after a request.

Ports:
- `clk_sys` in 1: system clock. All logic is on its rising edge.
- `reset` in 1: synchronous, active-high reset.
- `save_trig` in 1: level input (menu status bit). A rising edge requests an upload.
- `ioctl_upload_req` out 1: one-cycle pulse to hps_io requesting an upload.
- `ioctl_upload` in 1: level, high for the whole HPS upload session.
- `ioctl_rd` in 1: one-cycle strobe, meaning "present the byte at `ioctl_addr`".
- `ioctl_addr` in 25: byte offset within the image.
- `ioctl_din` out 8: registered byte returned to hps_io.
- `mem_addr` out 16: RAM address.
- `mem_rd` out 1: high for one cycle when `mem_addr` is valid. The RAM returns `mem_q` one cycle later.
- `mem_q` in 8: RAM read data.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse when a session ends normally.
- `timeout_err` out 1: one-cycle pulse when a request times out.

## Operation
States:

- **IDLE**
  - A rising edge of `save_trig` (registered previous value compared against current) → REQ.
  - `ioctl_upload` going high without a request (HPS-initiated upload) → ACTIVE.
- **REQ**
  - Pulses `ioctl_upload_req` for one cycle, clears the timeout counter, then → WAIT.
- **WAIT**
  - Counts cycles.
  - `ioctl_upload` high → ACTIVE.
  - Counter reaching `TIMEOUT` → IDLE, with a `timeout_err` pulse.
- **ACTIVE**
  - `ioctl_rd` high → latch `ioctl_addr` into `off`, then → READ.
  - `ioctl_upload` low → IDLE, with a `done` pulse.
- **READ**
  - If `off` < `SIZE`: `mem_rd`=1 and `mem_addr` = `BASE_ADDR` + `off[15:0]` (16-bit sum, wraps modulo 2^16), then → CAPTURE.
  - Otherwise: `ioctl_din` ← `FILL`, `mem_rd` stays 0, then → ACTIVE.
- **CAPTURE**
  - `ioctl_din` ← `mem_q`, then → ACTIVE.

Boundary rules:
- The `off` < `SIZE` comparison is a 25-bit unsigned compare. Offsets of 2^16 and above must return `FILL`; they must never alias into RAM.
- An `ioctl_rd` that arrives in READ or CAPTURE sets `pend`, together with its address, and is serviced on the cycle the block returns to ACTIVE. A second strobe while `pend` is set overwrites it (last request wins).
- `ioctl_upload` falling while in READ or CAPTURE: finish the current byte, then → IDLE with a `done` pulse. `pend` is discarded.
- `save_trig` edges outside IDLE are ignored and are not queued.
- `ioctl_rd` in IDLE, REQ or WAIT is ignored.
- `mem_addr` holds its last value when `mem_rd`=0.

## Timing
- Reset values:
  - State IDLE.
  - `ioctl_din`=8'h00, `mem_addr`=16'h0000.
  - `mem_rd`, `ioctl_upload_req`, `busy`, `done`, `timeout_err` all 0.
  - `pend`=0, timeout counter=0.
  - Reset asserted in any state returns to IDLE on the next edge. No `done` is emitted.
- Read latency, with `ioctl_rd` high in cycle T (state ACTIVE):
  - `mem_rd`/`mem_addr` are valid in T+1.
  - `mem_q` is valid in T+2.
  - `ioctl_din` is updated at the end of T+2 and valid from T+3.
  - A FILL byte is valid from T+2.
- `ioctl_din` holds its value until the next byte is captured.
- Consecutive `ioctl_rd` strobes spaced 3 or more cycles apart are served with no loss.
- `busy` goes high in the cycle after the IDLE exit and low in the cycle after the return to IDLE.
- The `done` pulse coincides with the first IDLE cycle.

## Test plan
- **Triggered upload.** Preload RAM[0x7000]=0x5A. Raise `save_trig` → `ioctl_upload_req` pulses once and `busy`=1. Assert `ioctl_upload` → state ACTIVE. Strobe `ioctl_rd` with addr 0 → `mem_addr`=0x7000 at T+1 and `ioctl_din`=0x5A at T+3.
- **Last byte and range check.** Addr 0x8FFF → `mem_addr`=0xFFFF, RAM data returned. Addr 0x9000 and addr 0x10000 → `ioctl_din`=0xFF, with no `mem_rd` pulse.
- **Back-to-back strobes.** Strobe `ioctl_rd` at T (addr 1) and T+1 (addr 2) → both bytes delivered in order, the second valid by T+6. A third strobe at T+2 (addr 3) replaces the pending addr 2.
- **Timeout.** Set `TIMEOUT`=16 and trigger with no `ioctl_upload` → `timeout_err` pulses after 16 WAIT cycles, then IDLE and `busy`=0.
- **Session end mid-read.** Drop `ioctl_upload` during READ → byte still captured, then `done` pulse and IDLE.
- **Reset mid-read.** Assert `reset` during CAPTURE → all outputs return to reset values next cycle, with no `done`.
